// File: rtl/digit_blitter.sv
// digit_blitter: reader-side sequencer for the digit glyph ROM.
// Accepts "draw digit D at (x, y)" over valid/ready. It sweeps the glyph's ROM bytes row-major and
// writes each returned byte into an 8-bit-per-pixel frame buffer. The ROM read latency is one
// cycle, so the write side runs one cycle behind the address side.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_valid_i/ready_o    request handshake; req_digit_i, req_x_i, req_y_i are the payload
//   rom_number_o/addr_o    registered glyph select and byte address to the ROM
//   rom_data_i             ROM byte for the address presented the previous cycle
//   fb_we_o/addr_o/wdata_o frame-buffer write port
//   busy_o                 request in progress
//   done_o                 one-cycle pulse on the drain cycle
module digit_blitter #(
  parameter int unsigned GLYPH_W        = 9,
  parameter int unsigned GLYPH_H        = 15,
  parameter int unsigned FB_W           = 640,
  parameter int unsigned FB_H           = 480,
  parameter int unsigned FB_ADDR_W      = 19,
  parameter bit          TRANSPARENT_EN = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [3:0]           req_digit_i,
  input  logic [9:0]           req_x_i,
  input  logic [8:0]           req_y_i,
  output logic [3:0]           rom_number_o,
  output logic [7:0]           rom_addr_o,
  input  logic [7:0]           rom_data_i,
  output logic                 fb_we_o,
  output logic [FB_ADDR_W-1:0] fb_addr_o,
  output logic [7:0]           fb_wdata_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned ColW = $clog2(GLYPH_W);
  localparam int unsigned RowW = $clog2(GLYPH_H);

  localparam logic [7:0]           LastAddr = 8'(GLYPH_W * GLYPH_H - 1);
  localparam logic [ColW-1:0]      LastCol  = ColW'(GLYPH_W - 1);
  localparam logic [FB_ADDR_W-1:0] Stride   = FB_ADDR_W'(FB_W);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e state_q, state_d;

  // init_q keeps req_ready low while in reset and for the edge that releases it.
  logic                 init_q;
  logic                 accept;

  logic [3:0]           digit_q, digit_d;
  logic [9:0]           x_q, x_d;
  logic [8:0]           y_q, y_d;
  logic [7:0]           rom_addr_q, rom_addr_d;
  logic [ColW-1:0]      col_q, col_d;
  logic [RowW-1:0]      row_q, row_d;
  // Frame-buffer address of column 0 of the row currently being presented to the ROM.
  logic [FB_ADDR_W-1:0] base_q, base_d;

  // Write pipeline stage, aligned with rom_data_i.
  logic                 pv_q, pv_d;
  logic [FB_ADDR_W-1:0] pix_q, pix_d;
  logic                 clip_q, clip_d;

  assign accept = req_valid_i & req_ready_o;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StFetch;
      StFetch: if (rom_addr_q == LastAddr) state_d = StDrain;
      StDrain: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready_o  = init_q & (state_q == StIdle);
    busy_o       = (state_q != StIdle);
    done_o       = (state_q == StDrain);
    rom_number_o = digit_q;
    rom_addr_o   = rom_addr_q;
    fb_addr_o    = pix_q;
    fb_wdata_o   = rom_data_i;
    fb_we_o      = pv_q & ~clip_q & ~(TRANSPARENT_EN & (rom_data_i == 8'h00));
  end

  // Address walker
  always_comb begin
    digit_d    = digit_q;
    x_d        = x_q;
    y_d        = y_q;
    rom_addr_d = rom_addr_q;
    col_d      = col_q;
    row_d      = row_q;
    base_d     = base_q;
    if (accept) begin
      digit_d    = req_digit_i;
      x_d        = req_x_i;
      y_d        = req_y_i;
      rom_addr_d = '0;
      col_d      = '0;
      row_d      = '0;
      // The only multiply: the line base is stepped by the stride from here on.
      base_d     = FB_ADDR_W'(req_y_i) * Stride + FB_ADDR_W'(req_x_i);
    end else if ((state_q == StFetch) && (rom_addr_q != LastAddr)) begin
      rom_addr_d = rom_addr_q + 8'd1;
      if (col_q == LastCol) begin
        col_d  = '0;
        row_d  = row_q + RowW'(1);
        base_d = base_q + Stride;
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  // Pipeline stage: computed for the address presented now, consumed next cycle.
  always_comb begin
    pv_d   = (state_q == StFetch);
    pix_d  = base_q + FB_ADDR_W'(col_q);
    // 11-bit x and 10-bit y sums cannot wrap.
    clip_d = (({1'b0, x_q} + 11'(col_q)) >= 11'(FB_W)) |
             (({1'b0, y_q} + 10'(row_q)) >= 10'(FB_H));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      digit_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      rom_addr_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      base_q     <= '0;
      pv_q       <= 1'b0;
      pix_q      <= '0;
      clip_q     <= 1'b0;
    end else begin
      digit_q    <= digit_d;
      x_q        <= x_d;
      y_q        <= y_d;
      rom_addr_q <= rom_addr_d;
      col_q      <= col_d;
      row_q      <= row_d;
      base_q     <= base_d;
      pv_q       <= pv_d;
      pix_q      <= pix_d;
      clip_q     <= clip_d;
    end
  end

endmodule

// File: tb/tb_digit_blitter.sv
module tb_digit_blitter;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_digit;
  logic [9:0]  req_x;
  logic [8:0]  req_y;
  logic [3:0]  rom_number;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [7:0]  fb_wdata;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int rom_mode = 0;  // 0: addr+1, 1: zero on even addr, 2: all zero

  // Per-draw statistics gathered by draw()
  int nwr, first_addr, first_data, first_cyc, last_addr, last_data, last_cyc;
  int ndone, done_cyc, max_addr, n_addr_bad, n_clip_bad, n_busy_bad, n_rom_bad, n_num_bad;
  logic ready137;

  digit_blitter dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_digit_i (req_digit),
    .req_x_i     (req_x),
    .req_y_i     (req_y),
    .rom_number_o(rom_number),
    .rom_addr_o  (rom_addr),
    .rom_data_i  (rom_data),
    .fb_we_o     (fb_we),
    .fb_addr_o   (fb_addr),
    .fb_wdata_o  (fb_wdata),
    .busy_o      (busy),
    .done_o      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model with one-cycle registered latency
  always_ff @(posedge clk) begin
    if (rom_mode == 2) rom_data <= 8'h00;
    else if (rom_mode == 1 && !rom_addr[0]) rom_data <= 8'h00;
    else rom_data <= rom_addr + 8'd1;
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout got=%b want=1", req_ready);
    end
  endtask

  // Issue one request and observe cycles 1..137 after the accept edge.
  task automatic draw(input logic [3:0] d, input int x, input int y);
    int a, r, c, e;
    wait_ready();
    req_valid = 1'b1;
    req_digit = d;
    req_x = 10'(x);
    req_y = 9'(y);
    nwr = 0; first_addr = -1; first_data = -1; first_cyc = -1;
    last_addr = -1; last_data = -1; last_cyc = -1; ndone = 0; done_cyc = -1;
    max_addr = 0; n_addr_bad = 0; n_clip_bad = 0; n_busy_bad = 0; n_rom_bad = 0;
    n_num_bad = 0; ready137 = 1'b0;
    @(posedge clk);
    for (int cyc = 1; cyc <= 137; cyc++) begin
      @(negedge clk);
      if (cyc == 1) req_valid = 1'b0;
      if (fb_we === 1'b1) begin
        nwr++;
        if (nwr == 1) begin
          first_addr = int'(fb_addr); first_data = int'(fb_wdata); first_cyc = cyc;
        end
        last_addr = int'(fb_addr); last_data = int'(fb_wdata); last_cyc = cyc;
        if (int'(fb_addr) > max_addr) max_addr = int'(fb_addr);
        a = int'(fb_wdata) - 1;
        r = a / 9;
        c = a % 9;
        e = (y + r) * 640 + x + c;
        if (int'(fb_addr) != e) n_addr_bad++;
        if (x + c >= 640 || y + r >= 480) n_clip_bad++;
      end
      if (done === 1'b1) begin
        ndone++;
        done_cyc = cyc;
      end
      if (busy !== (cyc <= 136)) n_busy_bad++;
      if (cyc <= 135 && rom_addr !== 8'(cyc - 1)) n_rom_bad++;
      if (cyc <= 136 && rom_number !== d) n_num_bad++;
      if (cyc == 137) ready137 = req_ready;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_digit = '0; req_x = '0; req_y = '0;
    #23;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b want=0", req_ready); end
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL rst_fb_we got=%b want=0", fb_we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b want=0", done); end
    checks++; if (rom_addr !== 8'h00) begin errors++; $display("FAIL rst_rom_addr got=%0d want=0", rom_addr); end
    checks++; if (rom_number !== 4'h0) begin errors++; $display("FAIL rst_rom_number got=%0d want=0", rom_number); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_basic();
    rom_mode = 0;
    draw(4'd1, 10, 20);
    checks++; if (nwr != 135) begin errors++; $display("FAIL basic_nwr got=%0d want=135", nwr); end
    checks++; if (first_addr != 12810) begin errors++; $display("FAIL basic_first_addr got=%0d want=12810", first_addr); end
    checks++; if (first_data != 1) begin errors++; $display("FAIL basic_first_data got=%0d want=1", first_data); end
    checks++; if (first_cyc != 2) begin errors++; $display("FAIL basic_first_cyc got=%0d want=2", first_cyc); end
    checks++; if (last_addr != 21778) begin errors++; $display("FAIL basic_last_addr got=%0d want=21778", last_addr); end
    checks++; if (last_data != 135) begin errors++; $display("FAIL basic_last_data got=%0d want=135", last_data); end
    checks++; if (last_cyc != 136) begin errors++; $display("FAIL basic_last_cyc got=%0d want=136", last_cyc); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL basic_ndone got=%0d want=1", ndone); end
    checks++; if (done_cyc != 136) begin errors++; $display("FAIL basic_done_cyc got=%0d want=136", done_cyc); end
    checks++; if (ready137 !== 1'b1) begin errors++; $display("FAIL basic_ready137 got=%b want=1", ready137); end
    checks++; if (n_addr_bad != 0) begin errors++; $display("FAIL basic_addr_bad got=%0d want=0", n_addr_bad); end
    checks++; if (n_busy_bad != 0) begin errors++; $display("FAIL basic_busy_bad got=%0d want=0", n_busy_bad); end
    checks++; if (n_rom_bad != 0) begin errors++; $display("FAIL basic_rom_seq_bad got=%0d want=0", n_rom_bad); end
    checks++; if (n_num_bad != 0) begin errors++; $display("FAIL basic_rom_number_bad got=%0d want=0", n_num_bad); end
  endtask

  task automatic test_transparent();
    rom_mode = 1;
    draw(4'd1, 10, 20);
    checks++; if (nwr != 67) begin errors++; $display("FAIL transp_nwr got=%0d want=67", nwr); end
    checks++; if (first_addr != 12811) begin errors++; $display("FAIL transp_first_addr got=%0d want=12811", first_addr); end
    checks++; if (last_addr != 21777) begin errors++; $display("FAIL transp_last_addr got=%0d want=21777", last_addr); end
    checks++; if (last_data != 134) begin errors++; $display("FAIL transp_last_data got=%0d want=134", last_data); end
    checks++; if (n_addr_bad != 0) begin errors++; $display("FAIL transp_addr_bad got=%0d want=0", n_addr_bad); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL transp_ndone got=%0d want=1", ndone); end
  endtask

  task automatic test_clip();
    rom_mode = 0;
    draw(4'd5, 635, 470);
    checks++; if (nwr != 50) begin errors++; $display("FAIL clip_nwr got=%0d want=50", nwr); end
    checks++; if (max_addr > 307199) begin errors++; $display("FAIL clip_max_addr got=%0d want<=307199", max_addr); end
    checks++; if (first_addr != 301435) begin errors++; $display("FAIL clip_first_addr got=%0d want=301435", first_addr); end
    checks++; if (last_addr != 307199) begin errors++; $display("FAIL clip_last_addr got=%0d want=307199", last_addr); end
    checks++; if (n_clip_bad != 0) begin errors++; $display("FAIL clip_clipped_written got=%0d want=0", n_clip_bad); end
    checks++; if (n_addr_bad != 0) begin errors++; $display("FAIL clip_addr_bad got=%0d want=0", n_addr_bad); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL clip_ndone got=%0d want=1", ndone); end
  endtask

  task automatic test_back_to_back();
    int w1, w2, n;
    rom_mode = 0;
    wait_ready();
    req_valid = 1'b1; req_digit = 4'd3; req_x = 10'd0; req_y = 9'd0;
    w1 = 0;
    @(posedge clk);
    for (int cyc = 1; cyc <= 138; cyc++) begin
      @(negedge clk);
      if (cyc == 1) req_digit = 4'd7;
      if (cyc <= 137 && fb_we === 1'b1) w1++;
      if (cyc == 137) begin
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready137 got=%b want=1", req_ready); end
        checks++; if (rom_number !== 4'd3) begin errors++; $display("FAIL b2b_num137 got=%0d want=3", rom_number); end
      end
      if (cyc == 138) begin
        req_valid = 1'b0;
        checks++; if (rom_number !== 4'd7) begin errors++; $display("FAIL b2b_num138 got=%0d want=7", rom_number); end
        checks++; if (rom_addr !== 8'd0) begin errors++; $display("FAIL b2b_addr138 got=%0d want=0", rom_addr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy138 got=%b want=1", busy); end
        checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL b2b_overlap138 got=%b want=0", fb_we); end
      end
    end
    checks++; if (w1 != 135) begin errors++; $display("FAIL b2b_first_nwr got=%0d want=135", w1); end
    w2 = 0; n = 0;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      if (fb_we === 1'b1) w2++;
      n++;
    end
    checks++; if (w2 != 135) begin errors++; $display("FAIL b2b_second_nwr got=%0d want=135", w2); end
  endtask

  task automatic test_reset_mid();
    int n, nd, nw;
    rom_mode = 0;
    wait_ready();
    req_valid = 1'b1; req_digit = 4'd2; req_x = 10'd0; req_y = 9'd0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (rom_addr !== 8'd60 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++; if (rom_addr !== 8'd60) begin errors++; $display("FAIL midrst_reach60 got=%0d want=60", rom_addr); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL midrst_fb_we got=%b want=0", fb_we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b want=0", done); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%b want=0", req_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0; nw = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
      if (fb_we === 1'b1) nw++;
    end
    checks++; if (nd != 0) begin errors++; $display("FAIL midrst_done_after got=%0d want=0", nd); end
    checks++; if (nw != 0) begin errors++; $display("FAIL midrst_writes_after got=%0d want=0", nw); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_after got=%b want=1", req_ready); end
    draw(4'd4, 200, 100);
    checks++; if (nwr != 135) begin errors++; $display("FAIL midrst_fresh_nwr got=%0d want=135", nwr); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL midrst_fresh_ndone got=%0d want=1", ndone); end
    checks++; if (n_addr_bad != 0) begin errors++; $display("FAIL midrst_fresh_addr_bad got=%0d want=0", n_addr_bad); end
    checks++; if (first_addr != 64200) begin errors++; $display("FAIL midrst_fresh_first got=%0d want=64200", first_addr); end
  endtask

  task automatic test_digit_hi();
    rom_mode = 2;
    draw(4'd12, 100, 100);
    checks++; if (nwr != 0) begin errors++; $display("FAIL hi_nwr got=%0d want=0", nwr); end
    checks++; if (n_rom_bad != 0) begin errors++; $display("FAIL hi_rom_seq_bad got=%0d want=0", n_rom_bad); end
    checks++; if (n_num_bad != 0) begin errors++; $display("FAIL hi_rom_number_bad got=%0d want=0", n_num_bad); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL hi_ndone got=%0d want=1", ndone); end
    checks++; if (done_cyc != 136) begin errors++; $display("FAIL hi_done_cyc got=%0d want=136", done_cyc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_transparent();
    test_clip();
    test_back_to_back();
    test_reset_mid();
    test_digit_hi();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/digit_blitter.md
Name: digit_blitter

Overview:
Reader-side sequencer for the digit glyph ROM. It accepts a "draw digit D at (x, y)" request over a valid/ready handshake. It then walks the ROM address space of the selected glyph and writes each returned glyph byte into the 8-bit-per-pixel frame buffer at the matching screen location. It sits between the score/number formatting logic (request side) and the frame-buffer write port. It accounts for the ROM's one-cycle registered read latency.

Parameters:
GLYPH_W, 9, glyph width in pixels.
GLYPH_H, 15, glyph height in rows (GLYPH_W*GLYPH_H = 135 ROM bytes per digit).
FB_W, 640, frame-buffer width in pixels; also the row stride.
FB_H, 480, frame-buffer height in rows.
FB_ADDR_W, 19, frame-buffer address width.
TRANSPARENT_EN, 1, when 1 glyph bytes equal to 8'h00 are not written.

Ports:
clk  input  1  system clock, all state on posedge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  draw request present
req_ready  output  1  block can accept a request
req_digit  input  4  digit to draw (0-9; 10-15 accepted)
req_x  input  10  left column of glyph
req_y  input  9  top row of glyph
rom_number  output  4  digit select to glyph ROM (registered)
rom_addr  output  8  glyph byte address to ROM (registered)
rom_data  input  8  ROM byte, valid the cycle after rom_addr/rom_number are presented
fb_we  output  1  frame-buffer write strobe
fb_addr  output  FB_ADDR_W  frame-buffer pixel address
fb_wdata  output  8  pixel value
busy  output  1  request in progress
done  output  1  one-cycle pulse on the final pipeline slot

Behaviour:
- Reset (async, rst_n=0): state IDLE. All registers and outputs go to 0: req_ready=0 while rst_n=0, fb_we=0, done=0, busy=0, rom_addr=0, rom_number=0. req_ready rises the first cycle after deassertion. Reset mid-draw aborts the draw: no further writes and no done pulse.
- States:
  - IDLE: req_ready=1. On req_valid&req_ready at edge E, latch digit/x/y and go to FETCH.
  - FETCH: rom_addr = row*GLYPH_W + col, presented row-major, one address per cycle, 0..134. After address 134, go to DRAIN.
  - DRAIN: one cycle to consume the last ROM byte, then return to IDLE.
- req_ready=0 in FETCH and DRAIN. Requests are held off, never dropped.
- Timing relative to accept edge E (cycle 0):
  - Cycles 1..135: FETCH, rom_addr 0..134.
  - Cycle 136: DRAIN.
  - Cycle 137: IDLE, req_ready=1.
  - busy=1 in cycles 1..136.
  - done=1 in cycle 136 only.
- Write pipeline: a valid bit, plus the col/row of the address presented, is delayed one cycle so it aligns with rom_data.
  - In cycle k+1 (k = 1..135), the byte for the address presented in cycle k is a write candidate.
  - fb_wdata = rom_data for that candidate.
  - fb_addr = (y+row)*FB_W + (x+col). No multiplier: keep a line-base register, initialised to y*FB_W + x at accept (a single multiply at accept is acceptable) and advanced by FB_W on column wrap.
- fb_we=1 for a candidate unless either:
  - TRANSPARENT_EN=1 and rom_data==8'h00, or
  - the pixel is clipped: x+col >= FB_W or y+row >= FB_H. Compare at widths that cannot overflow (11-bit x, 10-bit y).
- Digits 10-15: the sequence runs normally and rom_number carries the value; ROM returns 0, so with TRANSPARENT_EN=1 nothing is written.
- rom_number holds the latched digit from cycle 1 through cycle 136.
- Back-to-back: a request held valid during the cycle-137 IDLE is accepted at that edge. Minimum period is 137 cycles.

Test Plan:
- Bench ROM model: one-cycle latency, byte = addr+1 (never zero). Request digit 1, x=10, y=20 -> 135 writes, first fb_addr 12810 with data 8'h01 in cycle 2, last fb_addr 21778 with data 8'h87 in cycle 136. done pulses exactly once, in cycle 136. req_ready=1 in cycle 137.
- ROM model returns 0 for even addresses, TRANSPARENT_EN=1 -> exactly 67 writes (odd addresses only), addresses unchanged from the previous case.
- x=635, y=470 -> writes only for col 0..4 and row 0..9 (50 writes). No write has an fb_addr beyond 307199.
- req_valid held high continuously, digits 3 then 7 -> second accept at cycle 137. rom_number changes 3->7 in cycle 138. No overlap of writes.
- Assert rst_n=0 asynchronously mid-FETCH (rom_addr=60) -> fb_we, busy and done drop immediately. No done pulse. After release, req_ready=1 and a fresh request renders fully.
- req_digit=12 with TRANSPARENT_EN=1 and ROM returning 0 -> 135-address sweep, zero writes, done still pulses.
